// File: rtl/placement_sequencer_pkg.sv
// Shared constants and types for the map placement sequencer:
// class/state enums, default geometry and the LFSR feedback polynomial.
package placement_sequencer_pkg;

    localparam int CLASS_NUM  = 3;
    localparam int CLASS_bits = 2;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [CLASS_bits-1:0] {
        CLS_NEST     = 2'd0,
        CLS_SUGAR    = 2'd1,
        CLS_OBSTACLE = 2'd2
    } entity_class_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SEED       = 3'd1,
        ST_PLACE      = 3'd2,
        ST_NEXT_CLASS = 3'd3,
        ST_DONE       = 3'd4
    } placement_state_t;

endpackage

// File: rtl/placement_sequencer_lfsr_32.sv
// 32-bit right-shifting Galois LFSR with synchronous load; a zero seed is
// replaced by 1 so the register can never lock up in the all-zero state.
module lfsr_32
    import placement_sequencer_pkg::*;
(
    input  logic        setup_clk,
    input  logic        RESET_SIM_n,
    input  logic        load,
    input  logic        enable,
    input  logic [31:0] seed,
    output logic [31:0] value
);

    logic [31:0] value_reg;

    always_ff @(posedge setup_clk or negedge RESET_SIM_n) begin
        if (!RESET_SIM_n) begin
            value_reg <= 32'h1;
        end else if (load) begin
            value_reg <= (seed == 32'h0) ? 32'h1 : seed;
        end else if (enable) begin
            value_reg <= {1'b0, value_reg[31:1]} ^ (value_reg[0] ? LFSR_TAPS : 32'h0);
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/placement_sequencer.sv
// Places CLASS_NUM classes of entities at random, in-bounds, collision-free
// coordinates, emitting one write strobe per accepted placement.
module placement_sequencer
    import placement_sequencer_pkg::*;
#(
    parameter int CLASS_NUM   = placement_sequencer_pkg::CLASS_NUM,
    parameter int CLASS_bits  = placement_sequencer_pkg::CLASS_bits,
    parameter int ID_bits     = 6,
    parameter int X_bits      = 8,
    parameter int Y_bits      = 7,
    parameter int PIXELS_X    = 160,
    parameter int PIXELS_Y    = 120,
    parameter int RETRY_LIMIT = 64
) (
    input  logic                          setup_clk,
    input  logic                          RESET_SIM_n,
    input  logic                          start,
    input  logic [31:0]                   seed,
    input  logic [CLASS_NUM*ID_bits-1:0]  cls_count,
    input  logic [CLASS_NUM*8-1:0]        cls_radius,
    output logic [X_bits-1:0]             collide_x,
    output logic [Y_bits-1:0]             collide_y,
    input  logic                          collision,
    output logic                          wr_valid,
    output logic [CLASS_bits-1:0]         wr_class,
    output logic [ID_bits-1:0]            wr_id,
    output logic [X_bits-1:0]             wr_x,
    output logic [Y_bits-1:0]             wr_y,
    output logic                          busy,
    output logic                          done,
    output logic [ID_bits+CLASS_bits-1:0] fail_count,
    output logic [2:0]                    state_o
);

    localparam int RETRY_bits = $clog2(RETRY_LIMIT + 1);
    localparam int FAIL_bits  = ID_bits + CLASS_bits;
    localparam int XW         = X_bits + 9;
    localparam int YW         = Y_bits + 9;

    placement_state_t      state_reg;
    logic [CLASS_bits-1:0] cls_reg;
    logic [ID_bits-1:0]    id_reg;
    logic [RETRY_bits-1:0] retry_reg;
    logic [FAIL_bits-1:0]  fail_reg;
    logic [ID_bits-1:0]    count_reg  [CLASS_NUM];
    logic [7:0]            radius_reg [CLASS_NUM];

    logic [ID_bits-1:0]    count_in   [CLASS_NUM];
    logic [7:0]            radius_in  [CLASS_NUM];

    genvar gi;
    generate
        for (gi = 0; gi < CLASS_NUM; gi++) begin : g_unpack
            assign count_in[gi]  = cls_count[gi*ID_bits +: ID_bits];
            assign radius_in[gi] = cls_radius[gi*8 +: 8];
        end
    endgenerate

    logic [31:0] lfsr_value;
    logic        unused_lfsr_bits;

    lfsr_32 u_lfsr (
        .setup_clk   (setup_clk),
        .RESET_SIM_n (RESET_SIM_n),
        .load        (state_reg == ST_SEED),
        .enable      (state_reg == ST_PLACE),
        .seed        (seed),
        .value       (lfsr_value)
    );

    assign unused_lfsr_bits = ^lfsr_value;

    logic                  in_place;
    logic                  start_take;
    logic [X_bits-1:0]     cand_x;
    logic [Y_bits-1:0]     cand_y;
    logic [ID_bits-1:0]    cur_count;
    logic [7:0]            cur_radius;
    logic                  id_done;
    logic                  fits;
    logic                  accept;
    logic                  retry_full;
    logic [ID_bits-1:0]    id_inc;
    logic [CLASS_bits-1:0] cls_inc;

    assign in_place   = (state_reg == ST_PLACE);
    assign start_take = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
    assign cand_x     = lfsr_value[X_bits+Y_bits-1 -: X_bits];
    assign cand_y     = lfsr_value[Y_bits-1:0];
    assign cur_count  = count_reg[cls_reg];
    assign cur_radius = radius_reg[cls_reg];
    assign id_done    = (id_reg == cur_count);
    assign id_inc     = id_reg + 1'b1;
    assign cls_inc    = cls_reg + 1'b1;
    assign retry_full = (retry_reg == RETRY_bits'(RETRY_LIMIT - 1));

    // Widened compares keep x+R / y+R from wrapping for large radii.
    assign fits = (XW'(cand_x) > XW'(cur_radius))
               && (XW'(cand_x) + XW'(cur_radius) < XW'(PIXELS_X))
               && (YW'(cand_y) > YW'(cur_radius))
               && (YW'(cand_y) + YW'(cur_radius) < YW'(PIXELS_Y));

    assign accept = in_place && !id_done && fits && !collision;

    always_ff @(posedge setup_clk or negedge RESET_SIM_n) begin
        if (!RESET_SIM_n) begin
            state_reg <= ST_IDLE;
            cls_reg   <= '0;
            id_reg    <= '0;
            retry_reg <= '0;
            fail_reg  <= '0;
            for (int i = 0; i < CLASS_NUM; i++) begin
                count_reg[i]  <= '0;
                radius_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start_take) begin
                        for (int i = 0; i < CLASS_NUM; i++) begin
                            count_reg[i]  <= count_in[i];
                            radius_reg[i] <= radius_in[i];
                        end
                        cls_reg   <= '0;
                        id_reg    <= '0;
                        retry_reg <= '0;
                        fail_reg  <= '0;
                        state_reg <= ST_SEED;
                    end
                end
                ST_SEED: state_reg <= ST_PLACE;
                ST_PLACE: begin
                    if (id_done) begin
                        state_reg <= ST_NEXT_CLASS;
                    end else if (accept || retry_full) begin
                        // Either placed or retry budget exhausted: move to the next id.
                        id_reg    <= id_inc;
                        retry_reg <= '0;
                        if (!accept && fail_reg != {FAIL_bits{1'b1}}) begin
                            fail_reg <= fail_reg + 1'b1;
                        end
                        if (id_inc == cur_count) begin
                            state_reg <= ST_NEXT_CLASS;
                        end
                    end else begin
                        retry_reg <= retry_reg + 1'b1;
                    end
                end
                ST_NEXT_CLASS: begin
                    if (cls_reg == CLASS_bits'(CLASS_NUM - 1)) begin
                        state_reg <= ST_DONE;
                    end else begin
                        cls_reg <= cls_inc;
                        id_reg  <= '0;
                        if (count_reg[cls_inc] != '0) begin
                            state_reg <= ST_PLACE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign collide_x  = in_place ? cand_x : '0;
    assign collide_y  = in_place ? cand_y : '0;
    assign wr_valid   = accept;
    assign wr_class   = cls_reg;
    assign wr_id      = id_reg;
    assign wr_x       = collide_x;
    assign wr_y       = collide_y;
    assign busy       = (state_reg == ST_SEED) || in_place || (state_reg == ST_NEXT_CLASS);
    assign done       = (state_reg == ST_DONE);
    assign fail_count = fail_reg;
    assign state_o    = state_reg;

endmodule

// File: tb/tb_placement_sequencer.sv
// Scoreboard bench for placement_sequencer: a reference model queues expected
// strobes per run, and a negedge monitor pops and compares each DUT strobe.
module tb_placement_sequencer;

    localparam int NCLS  = 3;
    localparam int IDB   = 6;
    localparam int RETRY = 64;

    logic             setup_clk = 1'b0;
    logic             RESET_SIM_n = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      seed = '0;
    logic [NCLS*IDB-1:0] cls_count = '0;
    logic [NCLS*8-1:0]   cls_radius = '0;
    logic [7:0]       collide_x;
    logic [6:0]       collide_y;
    logic             collision = 1'b0;
    logic             wr_valid;
    logic [1:0]       wr_class;
    logic [5:0]       wr_id;
    logic [7:0]       wr_x;
    logic [6:0]       wr_y;
    logic             busy;
    logic             done;
    logic [7:0]       fail_count;
    logic [2:0]       state_o;

    always #5 setup_clk = ~setup_clk;

    placement_sequencer dut (
        .setup_clk   (setup_clk),
        .RESET_SIM_n (RESET_SIM_n),
        .start       (start),
        .seed        (seed),
        .cls_count   (cls_count),
        .cls_radius  (cls_radius),
        .collide_x   (collide_x),
        .collide_y   (collide_y),
        .collision   (collision),
        .wr_valid    (wr_valid),
        .wr_class    (wr_class),
        .wr_id       (wr_id),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .busy        (busy),
        .done        (done),
        .fail_count  (fail_count),
        .state_o     (state_o)
    );

    typedef struct packed {
        logic [1:0] c;
        logic [5:0] id;
        logic [7:0] x;
        logic [6:0] y;
    } strobe_t;

    strobe_t exp_q[$];
    strobe_t log_q[$];
    strobe_t saved_q[$];
    int      cur_r[NCLS];
    int      m_cnt[NCLS];
    int      strobes_seen = 0;
    int      checks = 0;
    int      failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        logic [31:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    // Walks the placement rules over the same random stream and queues strobes.
    task automatic model(input logic [31:0] sd, input bit coll,
                         output int exp_fail, output int exp_place);
        logic [31:0] v;
        int x, y, r, retry;
        bit fin;
        v = (sd == 0) ? 32'h1 : sd;
        exp_fail = 0;
        exp_place = 0;
        if (m_cnt[0] == 0) begin
            v = lfsr_step(v);
            exp_place++;
        end
        for (int c = 0; c < NCLS; c++) begin
            r = cur_r[c];
            for (int id = 0; id < m_cnt[c]; id++) begin
                retry = 0;
                fin = 0;
                while (!fin) begin
                    x = int'(v[14:7]);
                    y = int'(v[6:0]);
                    v = lfsr_step(v);
                    exp_place++;
                    if (x > r && x + r < 160 && y > r && y + r < 120 && !coll) begin
                        exp_q.push_back('{c: 2'(c), id: 6'(id), x: 8'(x), y: 7'(y)});
                        fin = 1;
                    end else begin
                        retry++;
                        if (retry == RETRY) begin
                            exp_fail++;
                            fin = 1;
                        end
                    end
                end
            end
        end
    endtask

    always @(negedge setup_clk) begin : monitor
        strobe_t s;
        strobe_t e;
        int r;
        if (RESET_SIM_n && wr_valid) begin
            s = '{c: wr_class, id: wr_id, x: wr_x, y: wr_y};
            strobes_seen++;
            log_q.push_back(s);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe actual=%0h required=none", s);
            end else begin
                e = exp_q.pop_front();
                chk("strobe", s, e);
            end
            r = cur_r[wr_class];
            chk("strobe_in_bounds",
                (int'(wr_x) > r && int'(wr_x) + r < 160 && int'(wr_y) > r && int'(wr_y) + r < 120), 1);
        end
    end

    task automatic run(input logic [31:0] sd, input int c0, input int c1, input int c2,
                       input int r0, input int r1, input int r2, input bit coll,
                       input bit poke, input string tag, input int exp_strobes,
                       output int cyc);
        int exp_fail, exp_place, n0;
        m_cnt[0] = c0; m_cnt[1] = c1; m_cnt[2] = c2;
        cur_r[0] = r0; cur_r[1] = r1; cur_r[2] = r2;
        exp_q.delete();
        model(sd, coll, exp_fail, exp_place);
        n0 = strobes_seen;
        @(posedge setup_clk); #1;
        seed       = sd;
        cls_count  = {6'(c2), 6'(c1), 6'(c0)};
        cls_radius = {8'(r2), 8'(r1), 8'(r0)};
        collision  = coll;
        start      = 1'b1;
        @(posedge setup_clk); #1;
        start = 1'b0;
        chk({tag, "_seed_state"}, state_o, 3'd1);
        chk({tag, "_busy_after_start"}, busy, 1);
        chk({tag, "_done_dropped"}, done, 0);
        chk({tag, "_fail_cleared"}, fail_count, 0);
        cyc = 0;
        while (busy && cyc < 4000) begin
            if (poke && cyc == 2) begin
                start = 1'b1;
                cls_count = {6'd7, 6'd7, 6'd7};
            end else begin
                start = 1'b0;
            end
            cyc++;
            @(posedge setup_clk); #1;
        end
        start = 1'b0;
        chk({tag, "_busy_cycles"}, cyc, 1 + exp_place + NCLS);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_fail_count"}, fail_count, exp_fail);
        chk({tag, "_queue_drained"}, exp_q.size(), 0);
        if (exp_strobes >= 0) chk({tag, "_strobes"}, strobes_seen - n0, exp_strobes);
        $display("run %s seed=%08h strobes=%0d fail=%0d cycles=%0d",
                 tag, sd, strobes_seen - n0, fail_count, cyc);
        exp_q.delete();
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < NCLS; i++) begin
            cur_r[i] = 0;
            m_cnt[i] = 0;
        end

        #12;
        chk("reset_state", state_o, 3'd0);
        chk("reset_busy_done", {busy, done, wr_valid}, 3'b000);
        chk("reset_fail", fail_count, 0);
        chk("reset_collide", {collide_x, collide_y}, 0);
        @(negedge setup_clk);
        RESET_SIM_n = 1'b1;

        // Zero seed, counts {2,0,1}: strobes are class0 ids 0,1 then class2 id 0.
        log_q.delete();
        run(32'h0, 2, 0, 1, 5, 3, 4, 1'b0, 1'b0, "tA", 3, cyc);
        if (log_q.size() == 3) begin
            chk("tA_order", {log_q[0].c, log_q[0].id, log_q[1].c, log_q[1].id, log_q[2].c, log_q[2].id},
                {2'd0, 6'd0, 2'd0, 6'd1, 2'd2, 6'd0});
        end else begin
            chk("tA_log_size", log_q.size(), 3);
        end

        // Permanent collision: one skip after exactly RETRY PLACE cycles.
        run(32'h1234_5678, 1, 0, 0, 0, 0, 0, 1'b1, 1'b0, "tB", 0, cyc);
        chk("tB_fail_one", fail_count, 1);
        chk("tB_cycles", cyc, 1 + RETRY + NCLS);

        // Radius 80 cannot fit; wide compares must not wrap into an accept.
        run(32'h0000_ACE1, 5, 0, 0, 80, 0, 0, 1'b0, 1'b0, "tC", 0, cyc);
        chk("tC_fail_all", fail_count, 5);

        // Restart from DONE (clears fail_count) with a start poked mid-run.
        log_q.delete();
        run(32'hDEAD_BEEF, 3, 2, 4, 10, 6, 3, 1'b0, 1'b1, "tD", 9, cyc);
        saved_q = log_q;
        log_q.delete();
        run(32'hDEAD_BEEF, 3, 2, 4, 10, 6, 3, 1'b0, 1'b0, "tE", 9, cyc);
        chk("tE_repeat_len", log_q.size(), saved_q.size());
        for (int i = 0; i < log_q.size() && i < saved_q.size(); i++) begin
            chk("tE_repeat_strobe", log_q[i], saved_q[i]);
        end

        // All counts zero: last busy cycle is start+2+NCLS.
        run(32'h5, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, "tF", 0, cyc);
        chk("tF_cycles", cyc, 2 + NCLS);

        // Asynchronous reset in the middle of PLACE.
        @(posedge setup_clk); #1;
        seed = 32'h7;
        cls_count = {6'd5, 6'd5, 6'd5};
        collision = 1'b1;
        start = 1'b1;
        @(posedge setup_clk); #1;
        start = 1'b0;
        repeat (70) @(posedge setup_clk);
        #2;
        chk("tG_pre_state", state_o, 3'd2);
        chk("tG_pre_fail", fail_count, 1);
        RESET_SIM_n = 1'b0;
        #1;
        chk("tG_reset_state", state_o, 3'd0);
        chk("tG_reset_flags", {busy, done, wr_valid}, 3'b000);
        chk("tG_reset_fail", fail_count, 0);
        chk("tG_reset_collide", {collide_x, collide_y}, 0);
        $display("run tG async reset mid-PLACE state=%0d fail=%0d", state_o, fail_count);
        @(negedge setup_clk);
        RESET_SIM_n = 1'b1;
        collision = 1'b0;
        repeat (2) @(posedge setup_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
